// File: rtl/cpu_key_pkg.sv
// ---------------------------------------------------------------------------
// cpu_key_pkg
// Shared constants for the cpu_key push-button input PIO.
//   - Register word addresses on the Avalon-MM slave.
//   - EDGE_TYPE encodings selecting which debounced transition is captured.
//   - Helper that sizes the per-bit debounce counter.
// ---------------------------------------------------------------------------
package cpu_key_pkg;

    // Register map (word addressed). Address 1 is reserved: it reads as zero
    // and writes to it are ignored.
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } reg_addr_e;

    localparam logic [1:0] ADDR_DATA    = REG_DATA;
    localparam logic [1:0] ADDR_IRQMASK = REG_IRQMASK;
    localparam logic [1:0] ADDR_EDGECAP = REG_EDGECAP;

    // Edge polarity selection for the EDGE_TYPE parameter.
    localparam int EDGE_FALL = 0;  // key press (active-low input goes low)
    localparam int EDGE_RISE = 1;  // key release
    localparam int EDGE_ANY  = 2;  // either transition

    // Counter width for a debounce window of 'cycles' clocks. The counter only
    // has to reach cycles-1, so clog2(cycles) bits suffice; keep at least one
    // bit so the smallest legal window (2) still yields a real register.
    function automatic int cnt_width(input int cycles);
        if (cycles > 2)
            return $clog2(cycles);
        else
            return 1;
    endfunction

endpackage

// File: rtl/cpu_key_debounce.sv
// ---------------------------------------------------------------------------
// cpu_key_debounce
// One key input: two-register synchroniser followed by a stability counter.
// The debounced level only follows the synchronised input after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive clocks.
// Any cycle of agreement restarts the count, so short glitches are dropped.
//
// Ports
//   clk      system clock
//   reset_n  synchronous active-low reset
//   raw      asynchronous key input (active-low, idles high)
//   level    debounced level, resets high (key released)
// ---------------------------------------------------------------------------
module cpu_key_debounce
    import cpu_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // ---- stage p0/p1: metastability filter, reset to the idle (high) level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: stability counter and debounced level
    // The counter runs only while the synchronised input disagrees with the
    // accepted level. On the clock where the DEBOUNCE_CYCLES-th consecutive
    // disagreement is seen (counter already at DEBOUNCE_CYCLES-1) the level
    // flips and the counter returns to zero, so it never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (sync_p1 == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_key.sv
// ---------------------------------------------------------------------------
// cpu_key
// Avalon-MM slave input PIO for up to 32 active-low push-buttons. Each key is
// synchronised and debounced, debounced transitions of the selected polarity
// are captured in a sticky EDGECAP register, and a registered level
// interrupt is raised while any captured edge is enabled in IRQMASK.
//
// Register map (word addressed, bits above WIDTH read 0)
//   0 DATA     RO  debounced key levels
//   1 reserved RO  reads 0, writes ignored
//   2 IRQMASK  RW  per-key interrupt enable
//   3 EDGECAP  RW  captured edges; a write clears (see build option below)
//
// Build option
//   CPU_KEY_BITCLEAR_EN  defined  : EDGECAP write clears only bits written 1
//                        undefined: any EDGECAP write clears every bit
//   In both builds an edge arriving in the same cycle as a clear wins.
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     register select (word address)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     raw asynchronous key inputs, active-low
//   readdata    read data, combinational from address (zero wait states)
//   irq         level interrupt to the CPU
// ---------------------------------------------------------------------------
module cpu_key
    import cpu_key_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_FALL
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] level;      // debounced key levels
    logic [WIDTH-1:0] level_p1;   // debounced levels one clock earlier
    logic [WIDTH-1:0] edge_hit;   // transitions of the selected polarity
    logic [WIDTH-1:0] clr;        // EDGECAP bits cleared by this cycle's write
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic             wr;
    logic             wr_mask;
    logic             wr_cap;
    logic             unused_wdata;

    // Picks the transitions reported as edges from the current and previous
    // debounced level vectors.
    function automatic logic [WIDTH-1:0] edge_sel(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] prev
    );
        case (EDGE_TYPE)
            EDGE_RISE: return ~prev & cur;
            EDGE_ANY:  return prev ^ cur;
            default:   return prev & ~cur;
        endcase
    endfunction

    // ---- stages p0..p2: per-key synchroniser and debounce
    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        cpu_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (in_port[i]),
            .level   (level[i])
        );
    end

    // ---- stage p3: delayed copy for edge detection
    // Resets to the same all-ones value as the debounced levels, so releasing
    // reset can never look like a transition.
    always_ff @(posedge clk) begin
        if (!reset_n)
            level_p1 <= '1;
        else
            level_p1 <= level;
    end

    assign edge_hit = edge_sel(level, level_p1);

    // Bus decode. Only the low WIDTH bits of writedata carry meaning; the
    // remainder is folded into a sink so it is visibly consumed.
    assign wr           = chipselect & ~write_n;
    assign wr_mask      = wr && (address == ADDR_IRQMASK);
    assign wr_cap       = wr && (address == ADDR_EDGECAP);
    assign unused_wdata = ^writedata;

`ifdef CPU_KEY_BITCLEAR_EN
    assign clr = wr_cap ? writedata[WIDTH-1:0] : '0;
`else
    assign clr = wr_cap ? '1 : '0;
`endif

    // ---- stage p4: software-visible registers
    // The new edge is OR-ed in after the clear so a simultaneous edge keeps
    // its EDGECAP bit set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask <= '0;
            cap  <= '0;
        end else begin
            if (wr_mask)
                mask <= writedata[WIDTH-1:0];
            cap <= (cap & ~clr) | edge_hit;
        end
    end

    // ---- stage p5: registered interrupt, one clock behind EDGECAP/IRQMASK
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |(cap & mask);
    end

    // Read mux: combinational, side-effect free, zero-extended to 32 bits.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = level;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = cap;
            default:      readdata = '0;
        endcase
    end

endmodule
